// File: rtl/ysyx_22050710_sram_arbiter.sv
// Two-requester SRAM arbiter: m0 (fetch) and m1 (load/store) share one single-port SRAM.
// Round-robin grant in IDLE, one response per grant, with a HOLD buffer for response backpressure.
module ysyx_22050710_sram_arbiter #(
    parameter int SRAM_ADDR_WD  = 32,
    parameter int SRAM_DATA_WD  = 64,
    parameter int SRAM_WMASK_WD = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,

    input  logic                     i_m0_valid,
    output logic                     o_m0_ready,
    input  logic [SRAM_ADDR_WD-1:0]  i_m0_addr,
    input  logic                     i_m0_wen,
    input  logic [SRAM_WMASK_WD-1:0] i_m0_wmask,
    input  logic [SRAM_DATA_WD-1:0]  i_m0_wdata,
    output logic                     o_m0_rvalid,
    output logic [SRAM_DATA_WD-1:0]  o_m0_rdata,
    input  logic                     i_m0_rready,

    input  logic                     i_m1_valid,
    output logic                     o_m1_ready,
    input  logic [SRAM_ADDR_WD-1:0]  i_m1_addr,
    input  logic                     i_m1_wen,
    input  logic [SRAM_WMASK_WD-1:0] i_m1_wmask,
    input  logic [SRAM_DATA_WD-1:0]  i_m1_wdata,
    output logic                     o_m1_rvalid,
    output logic [SRAM_DATA_WD-1:0]  o_m1_rdata,
    input  logic                     i_m1_rready,

    output logic [SRAM_ADDR_WD-1:0]  o_sram_addr,
    output logic                     o_sram_ren,
    output logic                     o_sram_wen,
    output logic [SRAM_WMASK_WD-1:0] o_sram_wmask,
    output logic [SRAM_DATA_WD-1:0]  o_sram_wdata,
    input  logic [SRAM_DATA_WD-1:0]  i_sram_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // Requester encoding shared by the pointer and the owner register: 0 = m0, 1 = m1.
    localparam logic SEL_M0 = 1'b0;
    localparam logic SEL_M1 = 1'b1;

    state_t                    state_q, state_d;
    logic                      rr_ptr_q, rr_ptr_d;
    logic                      owner_q, owner_d;
    logic                      is_write_q, is_write_d;
    logic [SRAM_DATA_WD-1:0]   rbuf_q, rbuf_d;

    logic                      accept_en;
    logic                      grant_m0;
    logic                      grant_m1;
    logic                      grant_any;
    logic                      grant_wen;
    logic                      resp_valid;
    logic [SRAM_DATA_WD-1:0]   resp_data;
    logic                      owner_rready;

    // Reset gates the grant path too, so ready/ren/wen drop the instant i_rst_n falls.
    always_comb begin
        accept_en = i_rst_n && (state_q == IDLE);
        grant_m0  = accept_en && i_m0_valid && (!i_m1_valid || (rr_ptr_q == SEL_M0));
        grant_m1  = accept_en && i_m1_valid && !grant_m0;
        grant_any = grant_m0 || grant_m1;
        grant_wen = grant_m1 ? i_m1_wen : i_m0_wen;
    end

    assign o_m0_ready = grant_m0;
    assign o_m1_ready = grant_m1;

    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        o_sram_addr  = '0;
        o_sram_wmask = '0;
        o_sram_wdata = '0;
        o_sram_ren   = 1'b0;
        o_sram_wen   = 1'b0;
        if (grant_m1) begin
            o_sram_addr  = i_m1_addr;
            o_sram_wmask = i_m1_wmask;
            o_sram_wdata = i_m1_wdata;
        end else if (grant_m0) begin
            o_sram_addr  = i_m0_addr;
            o_sram_wmask = i_m0_wmask;
            o_sram_wdata = i_m0_wdata;
        end
        if (grant_any) begin
            o_sram_ren = !grant_wen;
            o_sram_wen = grant_wen;
        end
    end

    // Response side: writes are acknowledged with zero data; HOLD replays the buffered word.
    always_comb begin
        resp_valid = i_rst_n && ((state_q == ACCESS) || (state_q == HOLD));
        resp_data  = '0;
        if (state_q == HOLD) begin
            resp_data = rbuf_q;
        end else if (state_q == ACCESS && !is_write_q) begin
            resp_data = i_sram_rdata;
        end
        owner_rready = (owner_q == SEL_M1) ? i_m1_rready : i_m0_rready;
    end

    always_comb begin
        o_m0_rvalid = 1'b0;
        o_m1_rvalid = 1'b0;
        o_m0_rdata  = '0;
        o_m1_rdata  = '0;
        if (resp_valid) begin
            if (owner_q == SEL_M1) begin
                o_m1_rvalid = 1'b1;
                o_m1_rdata  = resp_data;
            end else begin
                o_m0_rvalid = 1'b1;
                o_m0_rdata  = resp_data;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        is_write_d = is_write_q;
        rbuf_d     = rbuf_q;
        unique case (state_q)
            IDLE: begin
                if (grant_any) begin
                    owner_d    = grant_m1 ? SEL_M1 : SEL_M0;
                    is_write_d = grant_wen;
                    rr_ptr_d   = grant_m1 ? SEL_M0 : SEL_M1;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                if (owner_rready) begin
                    state_d = IDLE;
                end else begin
                    // SRAM read data is only valid this one cycle, so park it before stalling.
                    rbuf_d  = resp_data;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (owner_rready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the response buffer is reset too, so a stalled word never survives a reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= SEL_M0;
            owner_q    <= SEL_M0;
            is_write_q <= 1'b0;
            rbuf_q     <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            is_write_q <= is_write_d;
            rbuf_q     <= rbuf_d;
        end
    end

endmodule

// File: tb/tb_ysyx_22050710_sram_arbiter.sv
// Directed bench for the SRAM arbiter: a byte-masked SRAM model with one-cycle read latency,
// inputs driven on the falling edge and outputs sampled 1 ns later.
module tb_ysyx_22050710_sram_arbiter;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int MW = 8;

    localparam logic [DW-1:0] WORD_A    = 64'h1122334455667788;
    localparam logic [DW-1:0] WORD_B    = 64'hA5A5A5A55A5A5A5A;
    localparam logic [DW-1:0] STALE_RD  = 64'hBAD0BAD0BAD0BAD0;
    localparam logic [AW-1:0] ADDR_A    = 32'h80000000;
    localparam logic [AW-1:0] ADDR_B    = 32'h80000008;
    localparam logic [AW-1:0] ADDR_W    = 32'h80000100;

    logic          clk;
    logic          rst_n;
    logic          m0_valid, m0_ready, m0_wen, m0_rvalid, m0_rready;
    logic [AW-1:0] m0_addr;
    logic [MW-1:0] m0_wmask;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic          m1_valid, m1_ready, m1_wen, m1_rvalid, m1_rready;
    logic [AW-1:0] m1_addr;
    logic [MW-1:0] m1_wmask;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic [AW-1:0] sram_addr;
    logic          sram_ren, sram_wen;
    logic [MW-1:0] sram_wmask;
    logic [DW-1:0] sram_wdata, sram_rdata;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [256];

    ysyx_22050710_sram_arbiter #(
        .SRAM_ADDR_WD (AW),
        .SRAM_DATA_WD (DW),
        .SRAM_WMASK_WD(MW)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_m0_valid  (m0_valid),
        .o_m0_ready  (m0_ready),
        .i_m0_addr   (m0_addr),
        .i_m0_wen    (m0_wen),
        .i_m0_wmask  (m0_wmask),
        .i_m0_wdata  (m0_wdata),
        .o_m0_rvalid (m0_rvalid),
        .o_m0_rdata  (m0_rdata),
        .i_m0_rready (m0_rready),
        .i_m1_valid  (m1_valid),
        .o_m1_ready  (m1_ready),
        .i_m1_addr   (m1_addr),
        .i_m1_wen    (m1_wen),
        .i_m1_wmask  (m1_wmask),
        .i_m1_wdata  (m1_wdata),
        .o_m1_rvalid (m1_rvalid),
        .o_m1_rdata  (m1_rdata),
        .i_m1_rready (m1_rready),
        .o_sram_addr (sram_addr),
        .o_sram_ren  (sram_ren),
        .o_sram_wen  (sram_wen),
        .o_sram_wmask(sram_wmask),
        .o_sram_wdata(sram_wdata),
        .i_sram_rdata(sram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRAM model: read data is valid only in the cycle after ren, garbage otherwise.
    always @(posedge clk) begin
        sram_rdata <= sram_ren ? mem[sram_addr[10:3]] : STALE_RD;
        if (sram_wen) begin
            for (int b = 0; b < MW; b++) begin
                if (sram_wmask[b]) mem[sram_addr[10:3]][b*8 +: 8] <= sram_wdata[b*8 +: 8];
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic test_reset;
        rst_n = 1'b0;
        m0_valid = 1'b1; m0_addr = ADDR_A; m0_wen = 1'b0; m0_wmask = '0; m0_wdata = '0; m0_rready = 1'b1;
        m1_valid = 1'b1; m1_addr = ADDR_B; m1_wen = 1'b0; m1_wmask = '0; m1_wdata = '0; m1_rready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({m0_ready, m1_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready got %b expected 00", {m0_ready, m1_ready});
        end
        checks++;
        if ({sram_ren, sram_wen, m0_rvalid, m1_rvalid} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl got %b expected 0000", {sram_ren, sram_wen, m0_rvalid, m1_rvalid});
        end
    endtask

    task automatic test_contention;
        @(negedge clk); rst_n = 1'b1; #1;
        checks++;
        if ({m0_ready, m1_ready, sram_ren, sram_addr} !== {3'b101, ADDR_A}) begin
            errors++; $display("FAIL first_grant got r0=%b r1=%b ren=%b addr=%h expected m0 ren 80000000",
                               m0_ready, m1_ready, sram_ren, sram_addr);
        end
        @(negedge clk); m0_valid = 1'b0; #1;
        checks++;
        if ({m0_rvalid, m1_rvalid, m1_ready} !== 3'b100 || m0_rdata !== WORD_A) begin
            errors++; $display("FAIL m0_read_resp got rv0=%b rv1=%b r1=%b data=%h expected 1 0 0 %h",
                               m0_rvalid, m1_rvalid, m1_ready, m0_rdata, WORD_A);
        end
        @(negedge clk); #1;
        checks++;
        if ({m1_ready, m0_ready, m0_rvalid, sram_addr} !== {3'b100, ADDR_B}) begin
            errors++; $display("FAIL second_grant got r1=%b r0=%b rv0=%b addr=%h expected m1 at T+2",
                               m1_ready, m0_ready, m0_rvalid, sram_addr);
        end
        @(negedge clk); m1_valid = 1'b0; #1;
        checks++;
        if (m1_rvalid !== 1'b1 || m1_rdata !== WORD_B || m0_rvalid !== 1'b0) begin
            errors++; $display("FAIL m1_read_resp got rv1=%b data=%h rv0=%b expected 1 %h 0",
                               m1_rvalid, m1_rdata, m0_rvalid, WORD_B);
        end
        @(negedge clk); m0_valid = 1'b1; m1_valid = 1'b1; #1;
        checks++;
        if ({m0_ready, m1_ready} !== 2'b10) begin
            errors++; $display("FAIL rr_again_m0 got %b expected 10", {m0_ready, m1_ready});
        end
        @(negedge clk); m0_valid = 1'b0; #1;
        checks++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== WORD_A) begin
            errors++; $display("FAIL rr_again_m0_resp got rv=%b data=%h expected 1 %h", m0_rvalid, m0_rdata, WORD_A);
        end
        @(negedge clk); #1;
        checks++;
        if ({m0_ready, m1_ready} !== 2'b01) begin
            errors++; $display("FAIL rr_again_m1 got %b expected 01", {m0_ready, m1_ready});
        end
        @(negedge clk); m1_valid = 1'b0; #1;
        @(negedge clk); #1;
        checks++;
        if ({m0_rvalid, m1_rvalid, m0_ready, m1_ready} !== 4'b0000) begin
            errors++; $display("FAIL contention_idle got %b expected 0000", {m0_rvalid, m1_rvalid, m0_ready, m1_ready});
        end
    endtask

    task automatic test_write_read;
        @(negedge clk);
        m1_valid = 1'b1; m1_addr = ADDR_W; m1_wen = 1'b1; m1_wmask = 8'h0F; m1_wdata = 64'hDEADBEEF;
        #1;
        checks++;
        if ({m1_ready, sram_wen, sram_ren} !== 3'b110 || sram_wmask !== 8'h0F ||
            sram_wdata !== 64'hDEADBEEF || sram_addr !== ADDR_W) begin
            errors++; $display("FAIL write_issue got r=%b wen=%b ren=%b mask=%h wdata=%h addr=%h",
                               m1_ready, sram_wen, sram_ren, sram_wmask, sram_wdata, sram_addr);
        end
        @(negedge clk); m1_valid = 1'b0; m1_wen = 1'b0; #1;
        checks++;
        if (m1_rvalid !== 1'b1 || m1_rdata !== 64'h0 || {sram_ren, sram_wen} !== 2'b00) begin
            errors++; $display("FAIL write_ack got rv=%b data=%h ctrl=%b expected 1 0 00",
                               m1_rvalid, m1_rdata, {sram_ren, sram_wen});
        end
        @(negedge clk); m1_valid = 1'b1; #1;
        checks++;
        if ({m1_ready, sram_ren, sram_wen} !== 3'b110) begin
            errors++; $display("FAIL readback_issue got %b expected 110", {m1_ready, sram_ren, sram_wen});
        end
        @(negedge clk); m1_valid = 1'b0; #1;
        checks++;
        if (m1_rvalid !== 1'b1 || m1_rdata !== 64'h00000000DEADBEEF) begin
            errors++; $display("FAIL readback_data got rv=%b data=%h expected 1 00000000deadbeef", m1_rvalid, m1_rdata);
        end
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        m1_valid = 1'b1; m1_addr = ADDR_B; m1_wen = 1'b0; m1_rready = 1'b0; #1;
        checks++;
        if (m1_ready !== 1'b1) begin
            errors++; $display("FAIL bp_grant got %b expected 1", m1_ready);
        end
        @(negedge clk); m1_valid = 1'b0; m0_valid = 1'b1; m0_addr = ADDR_A; #1;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (m1_rvalid !== 1'b1 || m1_rdata !== WORD_B || m0_ready !== 1'b0 || sram_ren !== 1'b0) begin
                errors++; $display("FAIL bp_stall cycle %0d got rv=%b data=%h r0=%b ren=%b expected 1 %h 0 0",
                                   c, m1_rvalid, m1_rdata, m0_ready, sram_ren, WORD_B);
            end
            @(negedge clk); #1;
        end
        m1_rready = 1'b1; #1;
        checks++;
        if (m1_rvalid !== 1'b1 || m1_rdata !== WORD_B || m0_ready !== 1'b0) begin
            errors++; $display("FAIL bp_release got rv=%b data=%h r0=%b", m1_rvalid, m1_rdata, m0_ready);
        end
        @(negedge clk); #1;
        checks++;
        if ({m1_rvalid, m0_ready} !== 2'b01) begin
            errors++; $display("FAIL bp_next_grant got rv1=%b r0=%b expected 0 1", m1_rvalid, m0_ready);
        end
        @(negedge clk); m0_valid = 1'b0; #1;
        checks++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== WORD_A || m1_rvalid !== 1'b0) begin
            errors++; $display("FAIL bp_m0_resp got rv=%b data=%h rv1=%b", m0_rvalid, m0_rdata, m1_rvalid);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        m1_valid = 1'b1; m1_addr = ADDR_A; m1_wen = 1'b0; #1;
        @(negedge clk); m1_valid = 1'b0; #1;
        checks++;
        if (m1_rvalid !== 1'b1) begin
            errors++; $display("FAIL mid_pre_reset got rv=%b expected 1", m1_rvalid);
        end
        #1; rst_n = 1'b0; m0_valid = 1'b1; #1;
        checks++;
        if ({m0_ready, m1_ready, m0_rvalid, m1_rvalid, sram_ren, sram_wen} !== 6'b000000) begin
            errors++; $display("FAIL mid_reset_outputs got %b expected 000000",
                               {m0_ready, m1_ready, m0_rvalid, m1_rvalid, sram_ren, sram_wen});
        end
        @(negedge clk); m0_valid = 1'b0; rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            checks++;
            if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
                errors++; $display("FAIL stale_rvalid cycle %0d got %b expected 00", c, {m0_rvalid, m1_rvalid});
            end
        end
        @(negedge clk); m1_valid = 1'b1; m1_addr = ADDR_B; #1;
        checks++;
        if ({m1_ready, sram_ren} !== 2'b11) begin
            errors++; $display("FAIL post_reset_grant got %b expected 11", {m1_ready, sram_ren});
        end
        @(negedge clk); m1_valid = 1'b0; #1;
        checks++;
        if (m1_rvalid !== 1'b1 || m1_rdata !== WORD_B) begin
            errors++; $display("FAIL post_reset_resp got rv=%b data=%h expected 1 %h", m1_rvalid, m1_rdata, WORD_B);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[ADDR_A[10:3]] = WORD_A;
        mem[ADDR_B[10:3]] = WORD_B;
        test_reset();
        test_contention();
        test_write_read();
        test_backpressure();
        test_reset_mid();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_22050710_sram_arbiter.md
YSYX_22050710_SRAM_ARBITER -- requirements
Module: ysyx_22050710_sram_arbiter

Interface
REQ-001 SHALL have parameter SRAM_ADDR_WD, default 32, address width forwarded to the SRAM.
REQ-002 SHALL have parameter SRAM_DATA_WD, default 64, data width.
REQ-003 SHALL have parameter SRAM_WMASK_WD, default 8, byte write-mask width.
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 SHALL have port i_clk, input, 1, the single clock; all state updates on posedge.
REQ-006 SHALL have port i_rst_n, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have, for each requester X in {m0, m1}, the following request ports: i_X_valid (in, 1), o_X_ready (out, 1), i_X_addr (in, SRAM_ADDR_WD), i_X_wen (in, 1), i_X_wmask (in, SRAM_WMASK_WD), i_X_wdata (in, SRAM_DATA_WD).
REQ-008 SHALL have, for each requester X, the following response ports: o_X_rvalid (out, 1), o_X_rdata (out, SRAM_DATA_WD), i_X_rready (in, 1).
REQ-009 SHALL have SRAM-side ports o_sram_addr, o_sram_ren, o_sram_wen, o_sram_wmask and o_sram_wdata (out), and i_sram_rdata (in, SRAM_DATA_WD); i_sram_rdata is valid one cycle after o_sram_ren is asserted.
REQ-010 SHALL use m0 for instruction fetch and m1 for load/store; both requesters use the same protocol.

Function
REQ-011 SHALL implement a 3-state FSM: IDLE, ACCESS, HOLD.
REQ-012 In IDLE with any i_X_valid high, SHALL grant exactly one requester in the same cycle: assert its o_X_ready, drive o_sram_addr/wmask/wdata from it, assert o_sram_ren = ~i_X_wen or o_sram_wen = i_X_wen, and go to ACCESS.
REQ-013 SHALL register the grant owner, and whether the transaction is a write, at acceptance.
REQ-014 When both requesters are valid in IDLE, SHALL grant the requester selected by the round-robin pointer.
REQ-015 After every grant, the round-robin pointer SHALL point to the other requester.
REQ-016 When exactly one requester is valid, SHALL grant it regardless of the pointer; the pointer still toggles per REQ-015.
REQ-017 SHALL keep o_X_ready low in ACCESS and HOLD; no new request is accepted until the FSM returns to IDLE.
REQ-018 In ACCESS, SHALL assert o_owner_rvalid, with o_owner_rdata = i_sram_rdata for reads and 0 for writes (write acknowledge).
REQ-019 In ACCESS, if i_owner_rready is high, SHALL go to IDLE; otherwise SHALL capture the response data into a buffer and go to HOLD.
REQ-020 In HOLD, SHALL hold o_owner_rvalid high with the buffered data, stable, until i_owner_rready is high, then go to IDLE.
REQ-021 The non-owner's o_X_rvalid SHALL be 0 at all times.
REQ-022 Latency: request accepted in cycle T SHALL give rvalid in T+1; minimum issue interval is 2 cycles.
REQ-023 SRAM control outputs (ren, wen) SHALL be 0 outside the IDLE accept cycle.
REQ-024 An i_X_valid deasserted before acceptance SHALL be ignored without side effects; requesters hold request fields stable while valid and not ready.

Reset
REQ-025 On i_rst_n low, SHALL immediately (asynchronously) set FSM = IDLE and round-robin pointer = m0, clear the owner register and response buffer, and set all o_*_ready, o_*_rvalid, o_sram_ren and o_sram_wen to 0.
REQ-026 Reset asserted during ACCESS or HOLD SHALL discard the in-flight response; no rvalid is issued after reset release.
REQ-027 The first grant after reset release SHALL follow REQ-014 with the pointer at m0.

Verification
REQ-028 Single read: m0 reads addr 0x80000000, which holds 0x1122334455667788 -> ready in T; rvalid=1 with that data in T+1; IDLE in T+2.
REQ-029 Contention: m0 and m1 are both valid from reset -> m0 granted first and m1 second (ready at T+2); two further simultaneous requests -> order m0, m1 again.
REQ-030 Write then read: m1 writes 0xDEADBEEF with wmask 0x0F to 0x80000100 -> rvalid with rdata 0 in T+1; a subsequent read returns 0x00000000DEADBEEF.
REQ-031 Backpressure: m1 read with i_m1_rready low for 3 cycles -> FSM in HOLD, rvalid and data stable for 3 cycles, no ready on m0; completes in the cycle rready rises.
REQ-032 Reset mid-transaction: i_rst_n pulled low in ACCESS -> all outputs 0 at once; after release, no stale rvalid, and the next m1-only request is granted normally.
